// File: rtl/fc8_mem_pkg.sv
// Shared types and helpers for the FC8 banked memory controller:
// physical region classes, FSM states and region select/write rules.
package fc8_mem_pkg;

  typedef enum logic [2:0] {
    RGN_RAM  = 3'd0,
    RGN_RSVD = 3'd1,
    RGN_VRAM = 3'd2,
    RGN_SFR  = 3'd3,
    RGN_ROM  = 3'd4
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Region bases, expressed as values of phys[PHYS_W-1:15]
  localparam int unsigned RAM_BASE  = 32'd0;
  localparam int unsigned RSVD_BASE = 32'd1;
  localparam int unsigned VRAM_BASE = 32'd2;
  localparam int unsigned VRAM_LAST = 32'd3;
  localparam int unsigned SFR_BASE  = 32'd4;

  localparam logic [15:0] DEF_PAGE_REG_BASE = 16'h00FE;

  function automatic region_e decode_region(input int unsigned field);
    region_e rgn;
    if (field == RAM_BASE) begin
      rgn = RGN_RAM;
    end else if (field == RSVD_BASE) begin
      rgn = RGN_RSVD;
    end else if ((field >= VRAM_BASE) && (field <= VRAM_LAST)) begin
      rgn = RGN_VRAM;
    end else if (field == SFR_BASE) begin
      rgn = RGN_SFR;
    end else begin
      rgn = RGN_ROM;
    end
    return rgn;
  endfunction

  // ROM writes are dropped, so they select nothing on the external port
  function automatic logic [3:0] region_sel(input region_e rgn, input logic we);
    logic [3:0] sel;
    case (rgn)
      RGN_RAM:  sel = 4'b0001;
      RGN_VRAM: sel = 4'b0010;
      RGN_SFR:  sel = 4'b0100;
      RGN_ROM:  sel = we ? 4'b0000 : 4'b1000;
      default:  sel = 4'b0000;
    endcase
    return sel;
  endfunction

  function automatic logic region_writable(input region_e rgn);
    logic ok;
    case (rgn)
      RGN_RAM, RGN_VRAM, RGN_SFR: ok = 1'b1;
      default:                    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/fc8_addr_xlate.sv
// Combinational logical-to-physical translation through the page windows
// in the upper 32KB, followed by physical region decode.
module fc8_addr_xlate
  import fc8_mem_pkg::*;
#(
  parameter int PHYS_W      = 20,
  parameter int NUM_WINDOWS = 2,
  localparam int WIN_BITS   = $clog2(NUM_WINDOWS),
  localparam int OFS_W      = 15 - WIN_BITS,
  localparam int PAGE_W     = PHYS_W - OFS_W,
  localparam int WIN_IDX_W  = (WIN_BITS == 0) ? 1 : WIN_BITS
) (
  input  logic [15:0]                    addr,
  input  logic [NUM_WINDOWS*PAGE_W-1:0]  pages,
  output logic [PHYS_W-1:0]              phys,
  output region_e                        region
);

  logic [14:0]          low_s;
  logic [WIN_IDX_W-1:0] win_s;
  logic [PAGE_W-1:0]    page_s;
  logic [OFS_W-1:0]     ofs_s;

  // Window select and concatenation; the offset never carries into page bits
  always_comb begin
    low_s  = addr[14:0];
    win_s  = WIN_IDX_W'(low_s >> OFS_W);
    page_s = pages[win_s*PAGE_W +: PAGE_W];
    ofs_s  = low_s[OFS_W-1:0];
    if (addr[15]) begin
      phys = {page_s, ofs_s};
    end else begin
      phys = PHYS_W'(addr);
    end
    region = decode_region(32'(phys >> 15));
  end

endmodule

// File: rtl/fc8_banked_mem_ctrl.sv
// FC8 bank-switching memory controller: req/ack CPU handshake, page
// registers, one shared synchronous memory port with ROM wait states.
module fc8_banked_mem_ctrl
  import fc8_mem_pkg::*;
#(
  parameter int          PHYS_W        = 20,
  parameter int          NUM_WINDOWS   = 2,
  parameter logic [15:0] PAGE_REG_BASE = DEF_PAGE_REG_BASE,
  parameter int          ROM_WAIT      = 2,
  localparam int         PAGE_W        = PHYS_W - (15 - $clog2(NUM_WINDOWS))
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cpu_req,
  input  logic                           cpu_we,
  input  logic [15:0]                    cpu_addr,
  input  logic [7:0]                     cpu_wdata,
  output logic [7:0]                     cpu_rdata,
  output logic                           cpu_ack,
  output logic                           busy,
  output logic [PHYS_W-1:0]              mem_addr,
  output logic [7:0]                     mem_wdata,
  output logic                           mem_we,
  output logic [3:0]                     mem_sel,
  input  logic [7:0]                     mem_rdata,
  output logic [NUM_WINDOWS*PAGE_W-1:0]  page_regs
);

  state_e                        state_r, state_nxt_s;
  logic                          we_r, we_nxt_s;
  logic [7:0]                    wdata_r;
  logic [PHYS_W-1:0]             phys_r;
  region_e                       region_r, region_nxt_s;
  logic [3:0]                    wait_r, wait_nxt_s;
  logic [NUM_WINDOWS*PAGE_W-1:0] pages_r;
  logic [7:0]                    cpu_rdata_r;
  logic                          cpu_ack_r;
  logic [3:0]                    mem_sel_r, mem_sel_nxt_s;
  logic                          mem_we_r, mem_we_nxt_s;
  logic                          start_s;
  logic [PHYS_W-1:0]             xl_phys_s;
  region_e                       xl_region_s;
  logic [15:0]                   pr_ofs_s;
  logic                          pr_hit_s;
  logic [PAGE_W-1:0]             page_wdata_s;

  fc8_addr_xlate #(
    .PHYS_W      (PHYS_W),
    .NUM_WINDOWS (NUM_WINDOWS)
  ) u_xlate (
    .addr   (cpu_addr),
    .pages  (pages_r),
    .phys   (xl_phys_s),
    .region (xl_region_s)
  );

  // Page register hit detect; wrap of the subtraction rejects addresses below the base
  always_comb begin
    pr_ofs_s     = cpu_addr - PAGE_REG_BASE;
    pr_hit_s     = cpu_we && (pr_ofs_s < 16'(NUM_WINDOWS));
    page_wdata_s = PAGE_W'(cpu_wdata);
  end

  // Next-state, wait counter and next memory strobes
  always_comb begin
    state_nxt_s  = state_r;
    wait_nxt_s   = wait_r;
    start_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cpu_req) begin
          state_nxt_s = ST_ACCESS;
          start_s     = 1'b1;
          wait_nxt_s  = (xl_region_s == RGN_ROM) ? 4'(ROM_WAIT) : 4'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (wait_r == 4'd0) begin
          state_nxt_s = ST_RESP;
        end else begin
          wait_nxt_s = wait_r - 4'd1;
        end
      end
      ST_RESP:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase

    if (start_s) begin
      we_nxt_s     = cpu_we;
      region_nxt_s = xl_region_s;
    end else begin
      we_nxt_s     = we_r;
      region_nxt_s = region_r;
    end

    if (state_nxt_s == ST_ACCESS) begin
      mem_sel_nxt_s = region_sel(region_nxt_s, we_nxt_s);
      mem_we_nxt_s  = we_nxt_s && region_writable(region_nxt_s);
    end else begin
      mem_sel_nxt_s = 4'b0000;
      mem_we_nxt_s  = 1'b0;
    end
  end

  // State, access latches, strobes and CPU response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      we_r        <= 1'b0;
      wdata_r     <= 8'h00;
      phys_r      <= '0;
      region_r    <= RGN_RAM;
      wait_r      <= 4'd0;
      pages_r     <= '0;
      cpu_rdata_r <= 8'h00;
      cpu_ack_r   <= 1'b0;
      mem_sel_r   <= 4'b0000;
      mem_we_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      we_r      <= we_nxt_s;
      region_r  <= region_nxt_s;
      wait_r    <= wait_nxt_s;
      mem_sel_r <= mem_sel_nxt_s;
      mem_we_r  <= mem_we_nxt_s;
      cpu_ack_r <= (state_r == ST_RESP);
      if (start_s) begin
        wdata_r <= cpu_wdata;
        phys_r  <= xl_phys_s;
      end
      for (int i = 0; i < NUM_WINDOWS; i++) begin
        if (start_s && pr_hit_s && (pr_ofs_s == 16'(i))) begin
          pages_r[i*PAGE_W +: PAGE_W] <= page_wdata_s;
        end
      end
      // mem_rdata is valid during RESP, one cycle after the last strobe cycle
      if ((state_r == ST_RESP) && !we_r) begin
        cpu_rdata_r <= (region_r == RGN_RSVD) ? 8'hFF : mem_rdata;
      end
    end
  end

  assign busy      = (state_r != ST_IDLE);
  assign cpu_rdata = cpu_rdata_r;
  assign cpu_ack   = cpu_ack_r;
  assign mem_addr  = phys_r;
  assign mem_wdata = wdata_r;
  assign mem_we    = mem_we_r;
  assign mem_sel   = mem_sel_r;
  assign page_regs = pages_r;

endmodule

// File: tb/tb_fc8_banked_mem_ctrl.sv
// Directed bench for fc8_banked_mem_ctrl: expected read data is queued at issue
// and checked by an independent ack monitor; strobes and latency checked inline.
module tb_fc8_banked_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        busy;
  logic [19:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [7:0]  mem_rdata = 8'h00;
  logic [11:0] page_regs;
  logic [7:0]  rd_val = 8'h00;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_last = 8'h00;

  always #5 clk = ~clk;

  fc8_banked_mem_ctrl #(
    .PHYS_W        (20),
    .NUM_WINDOWS   (2),
    .PAGE_REG_BASE (16'h00FE),
    .ROM_WAIT      (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_sel   (mem_sel),
    .mem_rdata (mem_rdata),
    .page_regs (page_regs)
  );

  // Synchronous memory model: data appears the cycle after a selected cycle
  always @(posedge clk) mem_rdata <= (mem_sel != 4'b0000) ? rd_val : 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Ack monitor: every ack must match the oldest queued expectation
  always @(negedge clk) begin : mon
    logic [7:0] e;
    if (rst_n && cpu_ack) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("cpu_rdata", {24'h0, cpu_rdata}, {24'h0, e});
      end
    end
  end

  task automatic access(input string nm, input logic we, input logic [15:0] addr,
                        input logic [7:0] wd, input logic [7:0] rv, input logic [7:0] exp_rd,
                        input logic [3:0] exp_sel, input logic [19:0] exp_addr,
                        input int exp_lat, input bit hold);
    int n;
    int sel_cnt;
    if (!we) exp_last = exp_rd;
    exp_q.push_back(exp_last);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; rd_val = rv;
    @(negedge clk);
    if (!hold) cpu_req = 1'b0;
    chk({nm, "_sel"}, {28'h0, mem_sel}, {28'h0, exp_sel});
    chk({nm, "_addr"}, {12'h0, mem_addr}, {12'h0, exp_addr});
    chk({nm, "_we"}, {31'h0, mem_we}, {31'h0, (we && (exp_sel != 4'b0000))});
    if (we && (exp_sel != 4'b0000)) chk({nm, "_wdata"}, {24'h0, mem_wdata}, {24'h0, wd});
    n = 1;
    sel_cnt = 0;
    while (!cpu_ack && n < 20) begin
      if (mem_sel != 4'b0000) sel_cnt++;
      if (n < exp_lat) chk({nm, "_busy"}, {31'h0, busy}, 32'd1);
      @(negedge clk);
      n++;
      if (hold) cpu_req = busy;
    end
    chk({nm, "_lat"}, n, exp_lat);
    chk({nm, "_selcyc"}, sel_cnt, (exp_sel == 4'b0000) ? 0 : exp_lat - 2);
    cpu_req = 1'b0;
    @(negedge clk);
    chk({nm, "_ackpulse"}, {31'h0, cpu_ack}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'h0, cpu_ack}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_sel", {28'h0, mem_sel}, 32'd0);
    chk("rst_addr", {12'h0, mem_addr}, 32'd0);
    chk("rst_pages", {20'h0, page_regs}, 32'd0);
    chk("rst_rdata", {24'h0, cpu_rdata}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    //      name     we    addr      wd     rv     exp    sel      addr       lat hold
    access("rd1234", 1'b0, 16'h1234, 8'h00, 8'h5A, 8'h5A, 4'b0001, 20'h01234, 3, 1'b0);
    access("wrpg0",  1'b1, 16'h00FE, 8'h03, 8'h00, 8'h00, 4'b0001, 20'h000FE, 3, 1'b0);
    chk("pages_a", {20'h0, page_regs}, 32'h003);
    access("rdrsv1", 1'b0, 16'h8010, 8'h00, 8'h11, 8'hFF, 4'b0000, 20'h0C010, 3, 1'b0);
    access("wrpg0b", 1'b1, 16'h00FE, 8'h08, 8'h00, 8'h00, 4'b0001, 20'h000FE, 3, 1'b0);
    access("rdsfr",  1'b0, 16'h8010, 8'h00, 8'h77, 8'h77, 4'b0100, 20'h20010, 3, 1'b0);
    access("wrpg1",  1'b1, 16'h00FF, 8'h20, 8'h00, 8'h00, 4'b0001, 20'h000FF, 3, 1'b0);
    chk("pages_b", {20'h0, page_regs}, 32'h808);
    access("rdrom",  1'b0, 16'hC000, 8'h00, 8'hC3, 8'hC3, 4'b1000, 20'h80000, 5, 1'b0);
    access("wrrom",  1'b1, 16'hC000, 8'hAA, 8'h00, 8'h00, 4'b0000, 20'h80000, 5, 1'b0);
    access("rdwrap", 1'b0, 16'hFFFF, 8'h00, 8'h3C, 8'h3C, 4'b1000, 20'h83FFF, 5, 1'b0);
    access("wrpg0c", 1'b1, 16'h00FE, 8'h02, 8'h00, 8'h00, 4'b0001, 20'h000FE, 3, 1'b0);
    access("rdrsv2", 1'b0, 16'h8000, 8'h00, 8'h55, 8'hFF, 4'b0000, 20'h08000, 3, 1'b0);
    access("wrrsv",  1'b1, 16'h8000, 8'h66, 8'h00, 8'h00, 4'b0000, 20'h08000, 3, 1'b0);
    access("wrpg1b", 1'b1, 16'h00FF, 8'hFF, 8'h00, 8'h00, 4'b0001, 20'h000FF, 3, 1'b0);
    chk("pages_c", {20'h0, page_regs}, 32'hFC2);
    access("rdtop",  1'b0, 16'hFFFF, 8'h00, 8'hE7, 8'hE7, 4'b1000, 20'hFFFFF, 5, 1'b0);
    access("wrpg0d", 1'b1, 16'h00FE, 8'h04, 8'h00, 8'h00, 4'b0001, 20'h000FE, 3, 1'b0);
    access("rdvram", 1'b0, 16'h8000, 8'h00, 8'h4D, 8'h4D, 4'b0010, 20'h10000, 3, 1'b0);
    access("wrvram", 1'b1, 16'h8001, 8'h12, 8'h00, 8'h00, 4'b0010, 20'h10001, 3, 1'b0);
    access("rdhold", 1'b0, 16'h0042, 8'h00, 8'h9E, 8'h9E, 4'b0001, 20'h00042, 3, 1'b1);

    // Reset in the middle of a ROM wait: strobes and pages clear at once, no ack follows
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hC000; rd_val = 8'h99;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("midrst_pre_sel", {28'h0, mem_sel}, 32'h8);
    chk("midrst_pre_addr", {12'h0, mem_addr}, 32'hFC000);
    rst_n = 1'b0;
    #1;
    chk("midrst_sel", {28'h0, mem_sel}, 32'd0);
    chk("midrst_busy", {31'h0, busy}, 32'd0);
    chk("midrst_pages", {20'h0, page_regs}, 32'd0);
    chk("midrst_ack", {31'h0, cpu_ack}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_rdata", {24'h0, cpu_rdata}, 32'd0);
    exp_last = 8'h00;
    access("rdpost", 1'b0, 16'h1234, 8'h00, 8'h21, 8'h21, 4'b0001, 20'h01234, 3, 1'b0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drain", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
